// File: rtl/ofdm_pkg.sv
// Shared constants, enums and bin-classification helpers for the OFDM TX symbol sequencer.
package ofdm_pkg;
  localparam int NFFT  = 64;
  localparam int NCP   = 16;
  localparam int NDATA = 48;
  localparam int NSAMP = NFFT + NCP;

  // Subcarrier walk k = -32..31 maps to bins 32..63, 0..31
  localparam logic [5:0] FIRST_BIN = 6'(NFFT / 2);
  localparam logic [5:0] LAST_BIN  = 6'(NFFT / 2 - 1);

  // Scrambler x^7 + x^4 + 1: taps on b7 (bit 6) and b4 (bit 3)
  localparam logic [6:0] LFSR_TAPS = 7'b1001000;
  localparam logic [6:0] LFSR_SEED = 7'b1111111;

  // Pilots at k = -21, -7, 7, 21; only k = 21 carries the inverted sign
  localparam logic [5:0] PILOT_BIN [4] = '{6'd43, 6'd57, 6'd7, 6'd21};
  localparam logic [3:0] PILOT_NEG = 4'b1000;

  typedef enum logic [1:0] {BIN_NULL, BIN_PILOT, BIN_DATA} bin_class_t;
  typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_START, ST_WAIT, ST_OUT} state_t;

  function automatic bin_class_t bin_class(input logic [5:0] bin);
    bin_class_t c;
    c = BIN_DATA;
    // DC bin plus the guard band k = 27..31, -32..-27 (bins 27..37)
    if (bin == 6'd0 || (bin >= 6'd27 && bin <= 6'd37)) c = BIN_NULL;
    for (int i = 0; i < 4; i++)
      if (bin == PILOT_BIN[i]) c = BIN_PILOT;
    return c;
  endfunction

  function automatic logic pilot_neg(input logic [5:0] bin);
    logic n;
    n = 1'b0;
    for (int i = 0; i < 4; i++)
      if (bin == PILOT_BIN[i]) n = PILOT_NEG[i];
    return n;
  endfunction
endpackage

// File: rtl/ofdm_pilot_lfsr.sv
// Per-symbol pilot polarity generator; pol = 1 means the pilots are inverted this symbol.
module ofdm_pilot_lfsr
  import ofdm_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic seed,
  input  logic step,
  output logic pol
);
  logic [6:0] state;
  logic       fb;

  assign fb  = ^(state & LFSR_TAPS);
  assign pol = fb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       state <= LFSR_SEED;
    else if (seed) state <= LFSR_SEED;
    else if (step) state <= {state[5:0], fb};
  end
endmodule

// File: rtl/ofdm_symbol_ctrl.sv
// Builds each 64-bin frequency frame for the IFFT, runs the transform, and streams
// out cyclic prefix plus body through a 2-entry fall-through output FIFO.
module ofdm_symbol_ctrl
  import ofdm_pkg::*;
#(
  parameter int                W         = 16,
  parameter logic signed [W-1:0] PILOT_AMP = 16'sd11585
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                frm_start,
  input  logic [7:0]          frm_nsym,
  output logic                frm_busy,
  output logic                frm_done,
  input  logic                din_valid,
  output logic                din_ready,
  input  logic signed [W-1:0] din_re,
  input  logic signed [W-1:0] din_im,
  output logic                ifft_wr_en,
  output logic [5:0]          ifft_wr_addr,
  output logic signed [W-1:0] ifft_wr_re,
  output logic signed [W-1:0] ifft_wr_im,
  output logic                ifft_start,
  input  logic                ifft_done,
  output logic                ifft_rd_en,
  output logic [5:0]          ifft_rd_addr,
  input  logic signed [W-1:0] ifft_rd_re,
  input  logic signed [W-1:0] ifft_rd_im,
  output logic                dout_valid,
  input  logic                dout_ready,
  output logic signed [W-1:0] dout_re,
  output logic signed [W-1:0] dout_im,
  output logic                dout_last
);
  state_t              state;
  logic [5:0]          bin;
  logic [7:0]          nsym;
  logic [7:0]          sym_cnt;
  logic [6:0]          rd_idx;
  logic [6:0]          out_cnt;
  logic                rd_pending;
  logic [1:0]          fifo_cnt;
  logic signed [W-1:0] head_re, head_im, tail_re, tail_im;
  bin_class_t          cls;
  logic                pol, load_adv, last_sym, pop;
  logic signed [W-1:0] pilot_val;

  assign cls       = bin_class(bin);
  assign load_adv  = (state == ST_LOAD) && (cls != BIN_DATA || din_valid);
  assign din_ready = (state == ST_LOAD) && (cls == BIN_DATA);
  assign frm_busy  = (state != ST_IDLE);
  assign last_sym  = (sym_cnt == nsym - 8'd1);
  assign pilot_val = (pilot_neg(bin) ^ pol) ? -PILOT_AMP : PILOT_AMP;

  ofdm_pilot_lfsr u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .seed (state == ST_IDLE && frm_start),
    .step (load_adv && bin == LAST_BIN),
    .pol  (pol)
  );

  // Only issue a read when its data is guaranteed a FIFO slot on arrival
  assign ifft_rd_en   = (state == ST_OUT) && (rd_idx < 7'(NSAMP)) &&
                        (({1'b0, fifo_cnt} + {2'b00, rd_pending}) < 3'd2);
  // Adding 48 mod 64 maps index 0..15 onto prefix bins 48..63 and 16..79 onto 0..63
  assign ifft_rd_addr = ifft_rd_en ? 6'(rd_idx + 7'(NFFT - NCP)) : 6'd0;

  assign dout_valid = (fifo_cnt != 2'd0) || rd_pending;
  assign dout_re    = (fifo_cnt != 2'd0) ? head_re : (rd_pending ? ifft_rd_re : '0);
  assign dout_im    = (fifo_cnt != 2'd0) ? head_im : (rd_pending ? ifft_rd_im : '0);
  assign dout_last  = dout_valid && last_sym && (out_cnt == 7'(NSAMP - 1));
  assign pop        = dout_valid && dout_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      bin          <= '0;
      nsym         <= '0;
      sym_cnt      <= '0;
      rd_idx       <= '0;
      out_cnt      <= '0;
      ifft_wr_en   <= 1'b0;
      ifft_wr_addr <= '0;
      ifft_wr_re   <= '0;
      ifft_wr_im   <= '0;
      ifft_start   <= 1'b0;
      frm_done     <= 1'b0;
    end else begin
      ifft_wr_en <= 1'b0;
      ifft_start <= 1'b0;
      frm_done   <= 1'b0;
      case (state)
        ST_IDLE: if (frm_start) begin
          nsym    <= (frm_nsym == 8'd0) ? 8'd1 : frm_nsym;
          sym_cnt <= '0;
          bin     <= FIRST_BIN;
          state   <= ST_LOAD;
        end
        ST_LOAD: if (load_adv) begin
          ifft_wr_en   <= 1'b1;
          ifft_wr_addr <= bin;
          case (cls)
            BIN_DATA: begin
              ifft_wr_re <= din_re;
              ifft_wr_im <= din_im;
            end
            BIN_PILOT: begin
              ifft_wr_re <= pilot_val;
              ifft_wr_im <= '0;
            end
            default: begin
              ifft_wr_re <= '0;
              ifft_wr_im <= '0;
            end
          endcase
          bin <= bin + 6'd1;
          if (bin == LAST_BIN) state <= ST_START;
        end
        ST_START: begin
          ifft_start <= 1'b1;
          state      <= ST_WAIT;
        end
        ST_WAIT: if (ifft_done) begin
          rd_idx  <= '0;
          out_cnt <= '0;
          state   <= ST_OUT;
        end
        ST_OUT: begin
          if (ifft_rd_en) rd_idx <= rd_idx + 7'd1;
          if (pop) begin
            out_cnt <= out_cnt + 7'd1;
            if (out_cnt == 7'(NSAMP - 1)) begin
              if (last_sym) begin
                frm_done <= 1'b1;
                state    <= ST_IDLE;
              end else begin
                sym_cnt <= sym_cnt + 8'd1;
                bin     <= FIRST_BIN;
                state   <= ST_LOAD;
              end
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Read data bypasses the FIFO when it is empty, and is parked only if not taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pending <= 1'b0;
      fifo_cnt   <= '0;
      head_re    <= '0;
      head_im    <= '0;
      tail_re    <= '0;
      tail_im    <= '0;
    end else begin
      rd_pending <= ifft_rd_en;
      case (fifo_cnt)
        2'd0: if (rd_pending && !dout_ready) begin
          head_re  <= ifft_rd_re;
          head_im  <= ifft_rd_im;
          fifo_cnt <= 2'd1;
        end
        2'd1: if (pop) begin
          if (rd_pending) begin
            head_re <= ifft_rd_re;
            head_im <= ifft_rd_im;
          end else begin
            fifo_cnt <= 2'd0;
          end
        end else if (rd_pending) begin
          tail_re  <= ifft_rd_re;
          tail_im  <= ifft_rd_im;
          fifo_cnt <= 2'd2;
        end
        default: if (pop) begin
          head_re  <= tail_re;
          head_im  <= tail_im;
          fifo_cnt <= 2'd1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ofdm_symbol_ctrl.sv
// Table-driven bench for ofdm_symbol_ctrl with a behavioural IFFT that returns rd_re = address.
module tb_ofdm_symbol_ctrl;
  localparam int W = 16;
  localparam logic signed [W-1:0] BAD  = 16'sh0BAD;
  localparam logic signed [W-1:0] JUNK = 16'sh7777;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                frm_start = 1'b0;
  logic [7:0]          frm_nsym = 8'd0;
  logic                frm_busy, frm_done;
  logic                din_valid = 1'b0;
  logic                din_ready;
  logic signed [W-1:0] din_re = '0, din_im = '0;
  logic                ifft_wr_en;
  logic [5:0]          ifft_wr_addr;
  logic signed [W-1:0] ifft_wr_re, ifft_wr_im;
  logic                ifft_start;
  logic                ifft_done = 1'b0;
  logic                ifft_rd_en;
  logic [5:0]          ifft_rd_addr;
  logic signed [W-1:0] ifft_rd_re = BAD, ifft_rd_im = BAD;
  logic                dout_valid;
  logic                dout_ready = 1'b0;
  logic signed [W-1:0] dout_re, dout_im;
  logic                dout_last;

  always #5 clk = ~clk;

  ofdm_symbol_ctrl #(.W(W), .PILOT_AMP(16'sd11585)) dut (
    .clk(clk), .rst(rst), .frm_start(frm_start), .frm_nsym(frm_nsym),
    .frm_busy(frm_busy), .frm_done(frm_done),
    .din_valid(din_valid), .din_ready(din_ready), .din_re(din_re), .din_im(din_im),
    .ifft_wr_en(ifft_wr_en), .ifft_wr_addr(ifft_wr_addr),
    .ifft_wr_re(ifft_wr_re), .ifft_wr_im(ifft_wr_im),
    .ifft_start(ifft_start), .ifft_done(ifft_done),
    .ifft_rd_en(ifft_rd_en), .ifft_rd_addr(ifft_rd_addr),
    .ifft_rd_re(ifft_rd_re), .ifft_rd_im(ifft_rd_im),
    .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout_re(dout_re), .dout_im(dout_im), .dout_last(dout_last)
  );

  logic [83:0] outs;
  assign outs = {frm_busy, frm_done, din_ready, ifft_wr_en, ifft_wr_addr, ifft_wr_re,
                 ifft_wr_im, ifft_start, ifft_rd_en, ifft_rd_addr, dout_valid,
                 dout_re, dout_im, dout_last};

  typedef struct { logic [5:0] addr; logic signed [W-1:0] re; logic signed [W-1:0] im; int cyc; } wr_t;
  typedef struct { logic signed [W-1:0] re; logic signed [W-1:0] im; logic last; int cyc; } smp_t;
  typedef struct { logic [7:0] nsym_in; int nsym_eff; int vpct; int rpct; bit spur; bit poke; } vec_t;

  wr_t  wq[$];
  smp_t oq[$];
  int   done_q[$];
  int   cyc = 0, total = 0, bad = 0;
  int   vpct = 100, rpct = 100, lat = 6, timer = 0, dcount = 0;
  int   start_cyc = -1, done_cyc = -1, rden_cyc = -1;
  bit   spur_req = 0, spur_fire = 0, real_done = 0, req = 0, prev_stall = 0;
  logic [5:0] req_addr = '0;
  smp_t prev_s;
  int   exp_pol [6] = '{0, 0, 0, 0, 1, 1};

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Cycle engine: IFFT model after posedge, input drive at negedge, sampling 1 unit later
  initial begin
    forever begin
      @(posedge clk); #1;
      ifft_rd_re = req ? {10'd0, req_addr} : BAD;
      ifft_rd_im = req ? {10'd0, req_addr} + 16'sd1000 : BAD;
      ifft_done  = 1'b0;
      real_done  = 1'b0;
      if (rst) timer = 0;
      else if (timer > 0) begin
        timer--;
        if (timer == 0) begin ifft_done = 1'b1; real_done = 1'b1; end
      end
      if (spur_fire) begin ifft_done = 1'b1; spur_fire = 0; end
      @(negedge clk);
      din_valid  = ($urandom_range(0, 99) < vpct);
      din_re     = din_valid ? 16'(dcount) : JUNK;
      din_im     = din_valid ? -16'(dcount) : JUNK;
      dout_ready = ($urandom_range(0, 99) < rpct);
      #1;
      cyc++;
      req = ifft_rd_en;
      req_addr = ifft_rd_addr;
      if (ifft_rd_en && rden_cyc < 0) rden_cyc = cyc;
      if (ifft_start) begin timer = lat; if (start_cyc < 0) start_cyc = cyc; end
      if (ifft_done && real_done && done_cyc < 0) done_cyc = cyc;
      if (ifft_wr_en) wq.push_back('{ifft_wr_addr, ifft_wr_re, ifft_wr_im, cyc});
      if (din_valid && din_ready) dcount++;
      if (spur_req && wq.size() == 10) begin spur_fire = 1; spur_req = 0; end
      if (prev_stall && !rst) begin
        check("stall_valid", dout_valid, 1);
        check("stall_re", dout_re, prev_s.re);
        check("stall_im", dout_im, prev_s.im);
        check("stall_last", dout_last, prev_s.last);
      end
      prev_stall = dout_valid && !dout_ready;
      prev_s = '{dout_re, dout_im, dout_last, cyc};
      if (dout_valid && dout_ready) oq.push_back('{dout_re, dout_im, dout_last, cyc});
      if (frm_done) done_q.push_back(cyc);
    end
  end

  task automatic clear_logs();
    wq.delete(); oq.delete(); done_q.delete();
    start_cyc = -1; done_cyc = -1; rden_cyc = -1; dcount = 0;
  endtask

  task automatic pulse_start(input logic [7:0] n);
    @(negedge clk); frm_nsym = n; frm_start = 1'b1;
    @(negedge clk); frm_start = 1'b0; frm_nsym = 8'd0;
  endtask

  task automatic run_frame(input vec_t v, input int idx);
    int n, guard, s, j, k, er, ei, didx;
    bit neg;
    n = v.nsym_eff;
    clear_logs();
    vpct = v.vpct; rpct = v.rpct; spur_req = v.spur;
    pulse_start(v.nsym_in);
    #2 check($sformatf("v%0d_busy_after_start", idx), frm_busy, 1);
    if (v.poke) begin
      guard = 0;
      do begin @(negedge clk); #2; guard++; end while (!dout_valid && guard < 3000);
      check($sformatf("v%0d_reached_out", idx), dout_valid, 1);
      pulse_start(8'd3);
    end
    guard = 0;
    while (done_q.size() == 0 && guard < 3000 * n) begin @(negedge clk); guard++; end
    check($sformatf("v%0d_done_seen", idx), done_q.size(), 1);
    repeat (20) @(negedge clk);
    #2;
    spur_req = 0;
    check($sformatf("v%0d_done_pulses", idx), done_q.size(), 1);
    check($sformatf("v%0d_idle_after", idx), frm_busy, 0);
    check($sformatf("v%0d_wr_count", idx), wq.size(), 64 * n);
    didx = 0;
    for (int i = 0; i < wq.size() && i < 64 * n; i++) begin
      s = i / 64; j = i % 64; k = j - 32;
      if (j == 0) didx = 0;
      if (k <= -27 || k == 0 || k >= 27) begin er = 0; ei = 0; end
      else if (k == -21 || k == -7 || k == 7 || k == 21) begin
        neg = (k == 21) ^ (exp_pol[s] != 0);
        er = neg ? -11585 : 11585; ei = 0;
      end else begin
        er = s * 48 + didx; ei = -er; didx++;
      end
      check($sformatf("v%0d_wr_addr[%0d]", idx, i), wq[i].addr, (k + 64) % 64);
      check($sformatf("v%0d_wr_re[%0d]", idx, i), wq[i].re, er);
      check($sformatf("v%0d_wr_im[%0d]", idx, i), wq[i].im, ei);
    end
    check($sformatf("v%0d_out_count", idx), oq.size(), 80 * n);
    for (int i = 0; i < oq.size() && i < 80 * n; i++) begin
      j = i % 80;
      er = (j < 16) ? 48 + j : j - 16;
      check($sformatf("v%0d_out_re[%0d]", idx, i), oq[i].re, er);
      check($sformatf("v%0d_out_im[%0d]", idx, i), oq[i].im, er + 1000);
      check($sformatf("v%0d_out_last[%0d]", idx, i), oq[i].last, (i == 80 * n - 1) ? 1 : 0);
    end
    if (oq.size() > 0 && done_q.size() > 0)
      check($sformatf("v%0d_done_after_last", idx), done_q[0], oq[oq.size() - 1].cyc + 1);
    if (v.vpct == 100 && wq.size() >= 64) begin
      check($sformatf("v%0d_load_cycles", idx), wq[63].cyc - wq[0].cyc, 63);
      check($sformatf("v%0d_start_after_wr", idx), start_cyc, wq[63].cyc + 1);
    end
    if (v.rpct == 100 && oq.size() >= 80) begin
      check($sformatf("v%0d_rd_after_done", idx), rden_cyc, done_cyc + 1);
      check($sformatf("v%0d_dout_after_done", idx), oq[0].cyc, done_cyc + 2);
      check($sformatf("v%0d_out_contig", idx), oq[79].cyc - oq[0].cyc, 79);
    end
  endtask

  task automatic reset_mid(input bit in_out);
    int guard;
    clear_logs();
    vpct = 100; rpct = 100; lat = in_out ? 6 : 40;
    pulse_start(8'd2);
    guard = 0;
    if (in_out) while (oq.size() < 10 && guard < 1000) begin @(negedge clk); guard++; end
    else begin
      while (start_cyc < 0 && guard < 1000) begin @(negedge clk); guard++; end
      repeat (3) @(negedge clk);
      #2 check("rst_pre_in_wait", {frm_busy, dout_valid, din_ready}, 3'b100);
    end
    check($sformatf("rst%0d_reached", in_out), guard < 1000, 1);
    @(negedge clk); rst = 1'b1; #1;
    check($sformatf("rst%0d_outputs_zero", in_out), $countones(outs), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    clear_logs();
    repeat (300) @(negedge clk);
    #2;
    check($sformatf("rst%0d_no_done", in_out), done_q.size(), 0);
    check($sformatf("rst%0d_no_writes", in_out), wq.size(), 0);
    check($sformatf("rst%0d_no_output", in_out), oq.size(), 0);
    check($sformatf("rst%0d_idle", in_out), frm_busy, 0);
    lat = 6;
  endtask

  vec_t vecs [5];

  initial begin
    vecs[0] = '{8'd1, 1, 100, 100, 1'b0, 1'b0};  // one symbol, full rate
    vecs[1] = '{8'd6, 6, 100, 100, 1'b0, 1'b0};  // pilot polarity over six symbols
    vecs[2] = '{8'd1, 1, 100, 100, 1'b0, 1'b0};  // LFSR reseeded on the next frame
    vecs[3] = '{8'd2, 2,  50,  30, 1'b0, 1'b0};  // random stalls on both sides
    vecs[4] = '{8'd0, 1, 100, 100, 1'b1, 1'b1};  // nsym 0, stray done in LOAD, start in OUT

    repeat (3) @(negedge clk);
    #2 check("reset_outputs_zero", $countones(outs), 0);
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int t = 0; t < 5; t++) begin
      run_frame(vecs[t], t);
      $display("vector %0d: nsym=%0d writes=%0d samples=%0d total=%0d", t, vecs[t].nsym_in,
               wq.size(), oq.size(), total);
    end

    reset_mid(1'b0);
    $display("reset in WAIT done: total=%0d", total);
    reset_mid(1'b1);
    $display("reset in OUT done: total=%0d", total);
    run_frame(vecs[0], 5);
    $display("post-reset frame: writes=%0d samples=%0d total=%0d", wq.size(), oq.size(), total);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
